// File: rtl/ascon_block_packer.sv
// ---------------------------------------------------------------------------
// ascon_block_packer
//   Packs a byte stream big-endian into 64-bit ASCON-128 rate blocks and
//   presents them on a registered valid/ready output. One block is held in
//   assembly while another is held in the output register.
//
//   Build option: define ASCON_PACK_PAD_EN for ASCON 10* padding (0x80 after
//   the last byte, plus an extra pad block for multiple-of-8 messages).
//   Without it the last block is zero-filled and marked last with no extra block.
//
// Ports
//   clock_i       system clock, rising edge
//   resetb_i      asynchronous active-low reset
//   clear_i       synchronous abort, flushes all state
//   byte_i        input byte
//   byte_valid_i  byte_i valid
//   byte_last_i   byte_i is the final message byte
//   byte_ready_o  packer accepts a byte this cycle
//   data_o        packed block
//   data_valid_o  data_o valid
//   data_last_o   data_o is the final block
//   data_ready_i  consumer takes data_o this cycle
//   busy_o        message in progress or block pending
// ---------------------------------------------------------------------------
module ascon_block_packer #(
   parameter int unsigned RATE_BYTES = 8,
   parameter int unsigned CNT_W      = 3
) (
   input  logic        clock_i,
   input  logic        resetb_i,
   input  logic        clear_i,
   input  logic [7:0]  byte_i,
   input  logic        byte_valid_i,
   input  logic        byte_last_i,
   output logic        byte_ready_o,
   output logic [63:0] data_o,
   output logic        data_valid_o,
   output logic        data_last_o,
   input  logic        data_ready_i,
   output logic        busy_o
);

   localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(RATE_BYTES - 1);
   localparam logic [63:0]      PAD_BLOCK = 64'h8000_0000_0000_0000;

   typedef enum logic [1:0] {
      S_FILL = 2'd0,
`ifdef ASCON_PACK_PAD_EN
      S_PAD  = 2'd2,
`endif
      S_WAIT = 2'd1
   } state_t;

   state_t             state_q, state_d;
   logic [63:0]        asm_q, asm_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [63:0]        out_q, out_d;
   logic               val_q, val_d;
   logic               lst_q, lst_d;
   logic               blk_last_q, blk_last_d;
`ifdef ASCON_PACK_PAD_EN
   logic               pad_pend_q, pad_pend_d;
   logic               pad_next;
`endif

   logic               out_free;
   logic               byte_xfer;
   logic               blk_last;
   logic [63:0]        new_blk;
   logic [CNT_W+2:0]   byte_sh;

   always_comb begin
      state_d    = state_q;
      asm_d      = asm_q;
      cnt_d      = cnt_q;
      out_d      = out_q;
      val_d      = val_q;
      lst_d      = lst_q;
      blk_last_d = blk_last_q;
`ifdef ASCON_PACK_PAD_EN
      pad_pend_d = pad_pend_q;
`endif

      out_free  = !val_q || data_ready_i;
      byte_xfer = byte_valid_i && (state_q == S_FILL);

      // asm_q is cleared whenever a block leaves, so unused slots are already
      // zero and the new byte (and pad marker) can simply be OR-ed in.
      byte_sh = {CNT_W'(LAST_IDX - cnt_q), 3'b000};
      new_blk = asm_q | ({56'd0, byte_i} << byte_sh);
`ifdef ASCON_PACK_PAD_EN
      if (byte_last_i && (cnt_q != LAST_IDX))
         new_blk = new_blk | (64'h80 << {CNT_W'(LAST_IDX - cnt_q - 1'b1), 3'b000});
      // A full final block is not last: the pad block follows it.
      blk_last = byte_last_i && (cnt_q != LAST_IDX);
      pad_next = byte_last_i && (cnt_q == LAST_IDX);
`else
      blk_last = byte_last_i;
`endif

      if (val_q && data_ready_i) begin
         val_d = 1'b0;
         lst_d = 1'b0;
      end

      case (state_q)
         S_FILL: begin
            if (byte_xfer) begin
               if (!byte_last_i && (cnt_q != LAST_IDX)) begin
                  asm_d = new_blk;
                  cnt_d = cnt_q + 1'b1;
               end else if (out_free) begin
                  out_d = new_blk;
                  val_d = 1'b1;
                  lst_d = blk_last;
                  asm_d = '0;
                  cnt_d = '0;
`ifdef ASCON_PACK_PAD_EN
                  state_d = pad_next ? S_PAD : S_FILL;
`endif
               end else begin
                  asm_d      = new_blk;
                  blk_last_d = blk_last;
`ifdef ASCON_PACK_PAD_EN
                  pad_pend_d = pad_next;
`endif
                  state_d    = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            if (out_free) begin
               out_d = asm_q;
               val_d = 1'b1;
               lst_d = blk_last_q;
               asm_d = '0;
               cnt_d = '0;
`ifdef ASCON_PACK_PAD_EN
               state_d = pad_pend_q ? S_PAD : S_FILL;
`else
               state_d = S_FILL;
`endif
            end
         end
`ifdef ASCON_PACK_PAD_EN
         S_PAD: begin
            if (out_free) begin
               out_d   = PAD_BLOCK;
               val_d   = 1'b1;
               lst_d   = 1'b1;
               state_d = S_FILL;
            end
         end
`endif
         default: state_d = S_FILL;
      endcase

      if (clear_i) begin
         state_d    = S_FILL;
         asm_d      = '0;
         cnt_d      = '0;
         out_d      = '0;
         val_d      = 1'b0;
         lst_d      = 1'b0;
         blk_last_d = 1'b0;
`ifdef ASCON_PACK_PAD_EN
         pad_pend_d = 1'b0;
`endif
      end
   end

   always_ff @(posedge clock_i or negedge resetb_i) begin
      if (!resetb_i) begin
         state_q    <= S_FILL;
         asm_q      <= '0;
         cnt_q      <= '0;
         out_q      <= '0;
         val_q      <= 1'b0;
         lst_q      <= 1'b0;
         blk_last_q <= 1'b0;
`ifdef ASCON_PACK_PAD_EN
         pad_pend_q <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         asm_q      <= asm_d;
         cnt_q      <= cnt_d;
         out_q      <= out_d;
         val_q      <= val_d;
         lst_q      <= lst_d;
         blk_last_q <= blk_last_d;
`ifdef ASCON_PACK_PAD_EN
         pad_pend_q <= pad_pend_d;
`endif
      end
   end

   assign byte_ready_o = (state_q == S_FILL);
   assign data_o       = out_q;
   assign data_valid_o = val_q;
   assign data_last_o  = lst_q;
   assign busy_o       = (cnt_q != '0) || (state_q != S_FILL) || val_q;

endmodule

// File: tb/tb_ascon_block_packer.sv
// ---------------------------------------------------------------------------
// tb_ascon_block_packer
//   Directed bench for ascon_block_packer. Expected blocks are hand-computed
//   for both builds (with and without ASCON_PACK_PAD_EN).
// ---------------------------------------------------------------------------
module tb_ascon_block_packer;

   logic        clock_i      = 1'b0;
   logic        resetb_i     = 1'b0;
   logic        clear_i      = 1'b0;
   logic [7:0]  byte_i       = '0;
   logic        byte_valid_i = 1'b0;
   logic        byte_last_i  = 1'b0;
   logic        byte_ready_o;
   logic [63:0] data_o;
   logic        data_valid_o;
   logic        data_last_o;
   logic        data_ready_i = 1'b1;
   logic        busy_o;

   ascon_block_packer #(.RATE_BYTES(8), .CNT_W(3)) dut (
      .clock_i      (clock_i),
      .resetb_i     (resetb_i),
      .clear_i      (clear_i),
      .byte_i       (byte_i),
      .byte_valid_i (byte_valid_i),
      .byte_last_i  (byte_last_i),
      .byte_ready_o (byte_ready_o),
      .data_o       (data_o),
      .data_valid_o (data_valid_o),
      .data_last_o  (data_last_o),
      .data_ready_i (data_ready_i),
      .busy_o       (busy_o)
   );

   always #5 clock_i = ~clock_i;

`ifdef ASCON_PACK_PAD_EN
   localparam bit PAD = 1'b1;
`else
   localparam bit PAD = 1'b0;
`endif

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int rdy_low  = 0;
   bit mon_rdy  = 1'b0;

   logic [63:0] q_data[$];
   logic        q_last[$];
   int          q_cyc[$];

   // Block transfers are recorded midway between clock edges.
   always @(negedge clock_i) begin
      cyc++;
      if (resetb_i && data_valid_o && data_ready_i) begin
         q_data.push_back(data_o);
         q_last.push_back(data_last_o);
         q_cyc.push_back(cyc);
      end
      if (mon_rdy && !byte_ready_o) rdy_low++;
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input logic last);
      int n;
      n            = 0;
      byte_i       = b;
      byte_last_i  = last;
      byte_valid_i = 1'b1;
      @(negedge clock_i);
      while (!byte_ready_o && n < 64) begin
         @(negedge clock_i);
         n++;
      end
      check("byte_accept", 64'(byte_ready_o), 64'd1);
      @(posedge clock_i);
      #1;
      byte_valid_i = 1'b0;
      byte_last_i  = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clock_i);
      #1;
   endtask

   task automatic clr_q();
      q_data.delete();
      q_last.delete();
      q_cyc.delete();
   endtask

   task automatic check_blk(input string tag, input int i, input logic [63:0] d, input logic l);
      if (i < q_data.size()) begin
         check({tag, "_data"}, q_data[i], d);
         check({tag, "_last"}, 64'(q_last[i]), 64'(l));
      end else begin
         check({tag, "_present"}, 64'(q_data.size()), 64'(i + 1));
      end
   endtask

   initial begin
      // ---------------- reset state ----------------
      #1;
      check("rst_valid", 64'(data_valid_o), 64'd0);
      check("rst_data", data_o, 64'd0);
      check("rst_last", 64'(data_last_o), 64'd0);
      check("rst_busy", 64'(busy_o), 64'd0);
      idle(2);
      resetb_i = 1'b1;
      idle(1);
      check("idle_ready", 64'(byte_ready_o), 64'd1);

      // ---------------- 3-byte message ----------------
      clr_q();
      send_byte(8'h11, 1'b0);
      send_byte(8'h22, 1'b0);
      send_byte(8'h33, 1'b1);
      check("t1_latency", 64'(data_valid_o), 64'd1);
      idle(3);
      check("t1_count", 64'(q_data.size()), 64'd1);
      check_blk("t1_b0", 0, PAD ? 64'h1122_3380_0000_0000 : 64'h1122_3300_0000_0000, 1'b1);
      check("t1_busy_done", 64'(busy_o), 64'd0);

      // ---------------- 8-byte message ----------------
      clr_q();
      for (int i = 1; i <= 8; i++) send_byte(8'(i), i == 8);
      idle(4);
      check("t2_count", 64'(q_data.size()), PAD ? 64'd2 : 64'd1);
      check_blk("t2_b0", 0, 64'h0102_0304_0506_0708, !PAD);
      if (PAD) check_blk("t2_pad", 1, 64'h8000_0000_0000_0000, 1'b1);

      // ---------------- 20 bytes with backpressure ----------------
      clr_q();
      data_ready_i = 1'b0;
      for (int i = 1; i <= 16; i++) send_byte(8'(i), 1'b0);
      check("t3_ready_low", 64'(byte_ready_o), 64'd0);
      check("t3_hold_data", data_o, 64'h0102_0304_0506_0708);
      check("t3_hold_valid", 64'(data_valid_o), 64'd1);
      idle(2);
      check("t3_still_data", data_o, 64'h0102_0304_0506_0708);
      check("t3_busy", 64'(busy_o), 64'd1);
      data_ready_i = 1'b1;
      for (int i = 17; i <= 20; i++) send_byte(8'(i), i == 20);
      idle(4);
      check("t3_count", 64'(q_data.size()), 64'd3);
      check_blk("t3_b0", 0, 64'h0102_0304_0506_0708, 1'b0);
      check_blk("t3_b1", 1, 64'h090A_0B0C_0D0E_0F10, 1'b0);
      check_blk("t3_b2", 2, PAD ? 64'h1112_1314_8000_0000 : 64'h1112_1314_0000_0000, 1'b1);

      // ---------------- 24-byte stream ----------------
      clr_q();
      rdy_low = 0;
      mon_rdy = 1'b1;
      for (int i = 1; i <= 24; i++) send_byte(8'(i), i == 24);
      mon_rdy = 1'b0;
      idle(4);
      check("t4_no_stall", 64'(rdy_low), 64'd0);
      check("t4_count", 64'(q_data.size()), PAD ? 64'd4 : 64'd3);
      check_blk("t4_b0", 0, 64'h0102_0304_0506_0708, 1'b0);
      check_blk("t4_b1", 1, 64'h090A_0B0C_0D0E_0F10, 1'b0);
      check_blk("t4_b2", 2, 64'h1112_1314_1516_1718, !PAD);
      if (PAD) check_blk("t4_pad", 3, 64'h8000_0000_0000_0000, 1'b1);
      if (q_cyc.size() >= 3) begin
         check("t4_gap01", 64'(q_cyc[1] - q_cyc[0]), 64'd8);
         check("t4_gap12", 64'(q_cyc[2] - q_cyc[1]), 64'd8);
      end else begin
         check("t4_gap_count", 64'(q_cyc.size()), 64'd3);
      end

      // ---------------- asynchronous reset mid-message ----------------
      clr_q();
      data_ready_i = 1'b0;
      for (int i = 1; i <= 13; i++) send_byte(8'(i), 1'b0);
      check("t5_pre_valid", 64'(data_valid_o), 64'd1);
      #2;
      resetb_i = 1'b0;
      #1;
      check("t5_valid", 64'(data_valid_o), 64'd0);
      check("t5_data", data_o, 64'd0);
      check("t5_last", 64'(data_last_o), 64'd0);
      check("t5_busy", 64'(busy_o), 64'd0);
      @(posedge clock_i);
      #1;
      resetb_i     = 1'b1;
      data_ready_i = 1'b1;
      clr_q();
      send_byte(8'hAA, 1'b0);
      send_byte(8'hBB, 1'b1);
      idle(3);
      check("t5_count", 64'(q_data.size()), 64'd1);
      check_blk("t5_b0", 0, PAD ? 64'hAABB_8000_0000_0000 : 64'hAABB_0000_0000_0000, 1'b1);

      // ---------------- clear with a block pending ----------------
      clr_q();
      data_ready_i = 1'b0;
      send_byte(8'h11, 1'b0);
      send_byte(8'h22, 1'b0);
      send_byte(8'h33, 1'b1);
      check("t6_pre_valid", 64'(data_valid_o), 64'd1);
      clear_i = 1'b1;
      @(posedge clock_i);
      #1;
      clear_i = 1'b0;
      check("t6_valid", 64'(data_valid_o), 64'd0);
      check("t6_busy", 64'(busy_o), 64'd0);
      check("t6_data", data_o, 64'd0);
      check("t6_ready", 64'(byte_ready_o), 64'd1);
      data_ready_i = 1'b1;
      idle(3);
      check("t6_none", 64'(q_data.size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

endmodule
